// File: rtl/mipi_pkt_pkg.sv
// Shared framing constants, FSM states and header packing for the MIPI packet link.
// The receiver imports the same header function so field order cannot drift.
package mipi_pkt_pkg;

  localparam logic [31:0] SYNC_WORD  = 32'h8899FFEA;
  localparam int          WORD_W     = 48;
  localparam int          PAYLOAD_W  = 512;
  localparam int          DATA_WORDS = 11;
  localparam int          SR_W       = WORD_W * DATA_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_HDR,
    ST_DATA,
    ST_GAP
  } state_e;

  // Length bytes go out least-significant first, matching the far-end parser.
  function automatic logic [WORD_W-1:0] hdr_pack(input logic [7:0]  dtype,
                                                 input logic [31:0] dlen,
                                                 input logic [7:0]  phl_id);
    return {dtype, dlen[7:0], dlen[15:8], dlen[23:16], dlen[31:24], phl_id};
  endfunction

endpackage

// File: rtl/mipi_packet_tx.sv
// Serialises one 512-bit payload into SOF, HDR and 11 DATA words on the 48-bit packet bus.
// SOF appears one cycle after acceptance; payload_ready is high only in IDLE, the PHY cannot stall.
module mipi_packet_tx
  import mipi_pkt_pkg::*;
#(
  parameter logic [7:0] DTYPE      = 8'h01,
  parameter logic [7:0] PHL_ID     = 8'h00,
  parameter int         GAP_CYCLES = 1
) (
  input  logic                 tx_pixel_clk,
  input  logic                 rst,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic                 payload_valid,
  output logic                 payload_ready,
  output logic [WORD_W-1:0]    packet,
  output logic                 packet_valid,
  output logic                 busy,
  output logic [15:0]          pkt_id
);

  localparam logic [15:0] DATA_LAST = 16'(DATA_WORDS - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 2);
  localparam logic [31:0] DLEN      = 32'(DATA_WORDS);

  state_e              state_q, state_d;
  logic [SR_W-1:0]     shift_q, shift_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         pkt_id_q, pkt_id_d;
  logic [WORD_W-1:0]   packet_q, packet_d;
  logic                packet_valid_q, packet_valid_d;

  assign payload_ready = (state_q == ST_IDLE) && !rst;

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    pkt_id_d       = pkt_id_q;
    packet_d       = '0;
    packet_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (payload_valid && payload_ready) begin
          shift_d = {{(SR_W - PAYLOAD_W){1'b0}}, payload};
          state_d = ST_SOF;
        end
      end
      ST_SOF: begin
        packet_d       = {SYNC_WORD, pkt_id_q};
        packet_valid_d = 1'b1;
        state_d        = ST_HDR;
      end
      ST_HDR: begin
        packet_d       = hdr_pack(DTYPE, DLEN, PHL_ID);
        packet_valid_d = 1'b1;
        cnt_d          = '0;
        state_d        = ST_DATA;
      end
      ST_DATA: begin
        packet_d       = shift_q[SR_W-1 -: WORD_W];
        packet_valid_d = 1'b1;
        shift_d        = shift_q << WORD_W;
        if (cnt_q == DATA_LAST) begin
          pkt_id_d = pkt_id_q + 16'd1;
          cnt_d    = '0;
          // The IDLE cycle itself provides the last separating zero word.
          state_d  = (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_pixel_clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      shift_q        <= '0;
      cnt_q          <= '0;
      pkt_id_q       <= '0;
      packet_q       <= '0;
      packet_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      pkt_id_q       <= pkt_id_d;
      packet_q       <= packet_d;
      packet_valid_q <= packet_valid_d;
    end
  end

  assign packet       = packet_q;
  assign packet_valid = packet_valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign pkt_id       = pkt_id_q;

endmodule

// File: tb/tb_mipi_packet_tx.sv
// Bench for mipi_packet_tx: table vectors, random payloads against a framing model,
// back-to-back spacing on two gap settings, ID wrap and reset mid-packet.
module tb_mipi_packet_tx;

  localparam logic [31:0] SYNC = 32'h8899FFEA;

  logic          clk;
  logic          rst;
  logic [511:0]  payload, payload_4;
  logic          payload_valid, payload_valid_4;
  logic          payload_ready, payload_ready_4;
  logic [47:0]   packet, packet_4;
  logic          packet_valid, packet_valid_4;
  logic          busy, busy_4;
  logic [15:0]   pkt_id, pkt_id_4;

  int            errs;
  int            checks;
  logic [15:0]   model_id;

  mipi_packet_tx dut (
    .tx_pixel_clk (clk),
    .rst          (rst),
    .payload      (payload),
    .payload_valid(payload_valid),
    .payload_ready(payload_ready),
    .packet       (packet),
    .packet_valid (packet_valid),
    .busy         (busy),
    .pkt_id       (pkt_id)
  );

  mipi_packet_tx #(.DTYPE(8'hA5), .PHL_ID(8'h3C), .GAP_CYCLES(4)) dut4 (
    .tx_pixel_clk (clk),
    .rst          (rst),
    .payload      (payload_4),
    .payload_valid(payload_valid_4),
    .payload_ready(payload_ready_4),
    .packet       (packet_4),
    .packet_valid (packet_valid_4),
    .busy         (busy_4),
    .pkt_id       (pkt_id_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [527:0] act, input logic [527:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Word k of a packet: 0 = SOF, 1 = HDR, 2..12 = DATA[0..10] taken MSB-first from the padded payload.
  function automatic logic [47:0] model_word(input logic [15:0] id, input logic [511:0] p,
                                             input logic [7:0] dt, input logic [7:0] ph, input int k);
    logic [527:0] padded;
    padded = {16'h0, p};
    if (k == 0) return {SYNC, id};
    if (k == 1) return {dt, 8'd11, 8'd0, 8'd0, 8'd0, ph};
    return 48'(padded >> (48 * (12 - k)));
  endfunction

  function automatic logic [511:0] rand_payload();
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  // Entered at a negedge with the default DUT idle; leaves it idle again.
  task automatic send_pkt(input logic [511:0] p, output logic [47:0] d0, output logic [47:0] d10);
    logic [527:0] rx;
    int w;
    w  = 0;
    d0 = '0;
    d10 = '0;
    while (!payload_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_send", {527'd0, payload_ready}, 528'd1);
    payload       = p;
    payload_valid = 1'b1;
    @(negedge clk);
    payload_valid = 1'b0;
    payload       = ~p;
    chk("pre_sof_zero", {479'd0, packet_valid, packet}, 528'd0);
    rx = '0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      payload_valid = (k >= 1 && k <= 3);
      chk($sformatf("word%0d", k), {479'd0, packet_valid, packet},
          {479'd0, 1'b1, model_word(model_id, p, 8'h01, 8'h00, k)});
      if (k >= 2) rx = (rx << 48) | {480'd0, packet};
      if (k == 2) d0 = packet;
      if (k == 12) d10 = packet;
    end
    payload_valid = 1'b0;
    chk("loopback_payload", {16'd0, rx[511:0]}, {16'd0, p});
    model_id = model_id + 16'd1;
    chk("pkt_id_next", {512'd0, pkt_id}, {512'd0, model_id});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_zero", {478'd0, busy, packet_valid, packet}, 528'd0);
    end
  endtask

  typedef struct {
    logic [511:0] p;
    logic [47:0]  d0;
    logic [47:0]  d10;
  } vec_t;

  initial begin
    vec_t         tbl[4];
    logic [47:0]  d0, d10;
    logic [511:0] p;
    int           sof[3], sid[3], sof4[3], sid4[3];
    int           n, n4;
    bit           hdr4_next;

    errs = 0;
    checks = 0;
    model_id = '0;
    rst = 1'b1;
    payload = '0;
    payload_4 = '0;
    payload_valid = 1'b0;
    payload_valid_4 = 1'b0;

    tbl[0] = '{512'h1, 48'h000000000000, 48'h000000000001};
    tbl[1] = '{{512{1'b1}}, 48'h0000FFFFFFFF, 48'hFFFFFFFFFFFF};
    tbl[2] = '{{32'hDEADBEEF, 480'h0}, 48'h0000DEADBEEF, 48'h000000000000};
    tbl[3] = '{{464'h0, 48'h123456789ABC}, 48'h000000000000, 48'h123456789ABC};

    repeat (3) @(negedge clk);
    chk("rst_outputs", {461'd0, packet_valid, busy, pkt_id, packet, payload_ready}, 528'd0);
    chk("rst_outputs_4", {461'd0, packet_valid_4, busy_4, pkt_id_4, packet_4, payload_ready_4}, 528'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {526'd0, payload_ready, payload_ready_4}, 528'd3);

    for (int i = 0; i < 4; i++) begin
      send_pkt(tbl[i].p, d0, d10);
      chk($sformatf("tbl%0d_d0", i), {480'd0, d0}, {480'd0, tbl[i].d0});
      chk($sformatf("tbl%0d_d10", i), {480'd0, d10}, {480'd0, tbl[i].d10});
    end

    for (int i = 0; i < 6; i++) begin
      p = rand_payload();
      send_pkt(p, d0, d10);
    end

    // Back-to-back with payload_valid held high on both gap settings.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_id = '0;
    sof = '{0, 0, 0}; sid = '{0, 0, 0}; sof4 = '{0, 0, 0}; sid4 = '{0, 0, 0};
    n = 0; n4 = 0; hdr4_next = 1'b0;
    payload = rand_payload();
    payload_4 = rand_payload();
    payload_valid = 1'b1;
    payload_valid_4 = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (hdr4_next) begin
        chk("hdr_params", {480'd0, packet_4}, {480'd0, 8'hA5, 8'h0B, 24'h0, 8'h3C});
        hdr4_next = 1'b0;
      end
      if (packet_valid && packet[47:16] == SYNC && n < 3) begin
        sof[n] = c; sid[n] = int'(packet[15:0]); n++;
        if (n == 3) payload_valid = 1'b0;
      end
      if (packet_valid_4 && packet_4[47:16] == SYNC && n4 < 3) begin
        if (n4 == 0) hdr4_next = 1'b1;
        sof4[n4] = c; sid4[n4] = int'(packet_4[15:0]); n4++;
        if (n4 == 3) payload_valid_4 = 1'b0;
      end
    end
    payload_valid = 1'b0;
    payload_valid_4 = 1'b0;
    chk("b2b_count", 528'(n), 528'd3);
    chk("b2b_count_4", 528'(n4), 528'd3);
    chk("b2b_ids", {432'd0, 32'(sid[0]), 32'(sid[1]), 32'(sid[2])}, {432'd0, 32'd0, 32'd1, 32'd2});
    chk("b2b_ids_4", {432'd0, 32'(sid4[0]), 32'(sid4[1]), 32'(sid4[2])}, {432'd0, 32'd0, 32'd1, 32'd2});
    chk("b2b_spacing", {464'd0, 32'(sof[1] - sof[0]), 32'(sof[2] - sof[1])}, {464'd0, 32'd14, 32'd14});
    chk("b2b_spacing_4", {464'd0, 32'(sof4[1] - sof4[0]), 32'(sof4[2] - sof4[1])}, {464'd0, 32'd17, 32'd17});
    chk("b2b_pkt_id", {496'd0, pkt_id, pkt_id_4}, {496'd0, 16'd3, 16'd3});
    model_id = 16'd3;

    // ID wrap: preload the counter while idle.
    force dut.pkt_id_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.pkt_id_q;
    model_id = 16'hFFFF;
    @(negedge clk);
    chk("wrap_preload", {512'd0, pkt_id}, {512'd0, 16'hFFFF});
    send_pkt(rand_payload(), d0, d10);
    send_pkt(rand_payload(), d0, d10);

    // Reset while DATA[5] is on the bus.
    p = rand_payload();
    payload = p;
    payload_valid = 1'b1;
    @(negedge clk);
    payload_valid = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk);
    chk("pre_rst_data5", {479'd0, packet_valid, packet}, {479'd0, 1'b1, model_word(model_id, p, 8'h01, 8'h00, 7)});
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_packet", {461'd0, packet_valid, busy, pkt_id, packet, payload_ready}, 528'd0);
    rst = 1'b0;
    model_id = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", {478'd0, busy, packet_valid, packet}, 528'd0);
    end
    send_pkt(rand_payload(), d0, d10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
